alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the single-cycle datapath ALU.
- Takes a W-bit operand pair, opcode and PSW over a valid/ready handshake and executes the operation.
  - Decimal add runs one BCD digit per cycle; shifts run one bit per cycle.
- Returns the result and updated PSW over a held output handshake.
- Sits between the register file/operand fetch stage and the writeback/PSW register.

Parameters:
- W, 16, datapath width in bits; multiple of 8, >= 16.
- CW, 4, width of the shift-count field taken from op2[CW-1:0]; 2**CW >= W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand/opcode bundle valid.
- in_ready  out  1  block can accept a bundle.
- instr  in  5  opcode; bit0 = byte mode.
- upd_psw  in  1  1 = write flags into psw_o; 0 = psw_o = psw_i.
- op1  in  W  dst operand.
- op2  in  W  src operand / shift count.
- psw_i  in  16  PSW in; bit4 V, bit3 S, bit2 N, bit1 Z, bit0 C.
- out_valid  out  1  result bundle valid.
- out_ready  in  1  consumer accepts result.
- result  out  W  result.
- psw_o  out  16  updated PSW.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, out_valid=0, result=0, psw_o=0, in_ready=0 while rst high.
  - Any in-flight operation is discarded; no output is produced for it.
- States: IDLE -> EXEC -> DONE -> IDLE.
  - in_ready = (state==IDLE) && !rst.
  - Accept on an edge with in_valid && in_ready: latch instr, upd_psw, op1, op2, psw_i; go to EXEC; load the cycle counter.
- EXEC cycle count N, where accept is edge k and out_valid rises at edge k+N:
  - Single-cycle ops: N=1.
  - DADD: N=W/4 (word) or 2 (byte).
  - SRA/RRC: N=max(n,1), where n = op2[CW-1:0] clamped to W-1 (word) or 7 (byte).
- DONE:
  - result and psw_o are held stable while out_valid=1 and out_ready=0.
  - On an edge with out_valid && out_ready: out_valid=0, go to IDLE.
  - No accept is possible in that same cycle.
- Byte mode:
  - Operates on bits [7:0]; result[W-1:8] = op1[W-1:8].
  - Flags taken from bit 7 and bits [7:0].
- Opcodes (word/byte pairs, bit0 = byte):
  - ADD 0000x: dst+src.
  - ADDC 0001x: dst+src+C.
  - SUB 0010x: dst+~src+1.
  - SUBC 0011x: dst+~src+C.
  - DADD 0100x: BCD dst+src+C, low digit first; digit sum >9 subtracts 10 and carries 1 into the next digit.
  - CMP 0101x: result=op1; flags from dst+~src+1.
  - XOR 0110x, AND 0111x, OR 1000x.
  - SRA 1100x: arithmetic right shift by n.
  - RRC 1101x: rotate right through C by n.
  - Any other opcode: result=op1, psw_o=psw_i, N=1.
- Flags (only when upd_psw=1; all bits not named are passed from psw_i):
  - Arithmetic ops: C = carry out of the MSB (SUB/CMP: C=1 means no borrow). V = signed overflow of the operation. N = result MSB. Z = (result==0).
  - Logic ops: N and Z only.
  - DADD: C = decimal carry out of the top digit; N and Z from result.
  - SRA/RRC: C = last bit shifted out; N and Z from result. With n=0: result=op1, C unchanged, N and Z updated.
  - S is never modified.
- Simultaneous events: in_valid during EXEC/DONE is ignored; the source holds the bundle until in_ready.

Test Plan:
- ADD word, op1=0x7FFF, op2=0x0001, psw_i=0, upd_psw=1 -> after 1 EXEC cycle: result=0x8000, psw_o=0x0014 (V,N set).
- SUB.b, op1=0x1205, op2=0x0006 -> result=0x12FF, N=1, Z=0, C=0, V=0.
- DADD word, op1=0x0999, op2=0x0001, C=0 -> out_valid 4 cycles after accept, result=0x1000, C=0; repeat with op1=0x9999 -> result=0x0000, C=1, Z=1.
- SRA word, op1=0x8004, op2=3 -> out_valid 3 cycles after accept, result=0xF000, C=1, N=1; repeat with op2=0 -> result=0x8004, C=psw_i[0], latency 1.
- Backpressure: hold out_ready=0 for 5 cycles after ADD completes -> result/psw_o stable, in_ready=0, a second in_valid is not accepted; raise out_ready -> IDLE next edge, then the second bundle is accepted.
- Reset mid-DADD (assert rst in the 2nd EXEC cycle) -> out_valid=0, result=0, psw_o=0 immediately; after release, in_ready=1 and no stale output appears.

Source files
------------

// File: rtl/alu_seq.sv
// Multi-cycle ALU: accepts an operand bundle over valid/ready, runs BCD add one
// digit per cycle and shifts one bit per cycle, and holds the result until taken.
module alu_seq #(
    parameter int W  = 16,
    parameter int CW = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [4:0]   instr,
    input  logic         upd_psw,
    input  logic [W-1:0] op1,
    input  logic [W-1:0] op2,
    input  logic [15:0]  psw_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic [15:0]  psw_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_ADDC = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_SUBC = 4'h3;
    localparam logic [3:0] OP_DADD = 4'h4;
    localparam logic [3:0] OP_CMP  = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_OR   = 4'h8;
    localparam logic [3:0] OP_SRA  = 4'hC;
    localparam logic [3:0] OP_RRC  = 4'hD;

    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_TWO   = CW'(2);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] MAX_SH_W  = CW'(W - 1);
    localparam logic [CW-1:0] MAX_SH_B  = CW'(7);
    localparam logic [CW-1:0] DIGITS_W  = CW'(W / 4);

    state_t          state_r;
    logic [3:0]      op_r;
    logic            byte_r;
    logic            upd_r;
    logic [W-1:0]    op1_r;
    logic [W-1:0]    op2_r;
    logic [15:0]     psw_r;
    logic [W-1:0]    acc_r;
    logic            c_r;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   dig_r;
    logic            shen_r;

    logic [CW-1:0]   n_in_s;
    logic [CW-1:0]   n_clamp_s;
    logic [CW-1:0]   cnt_load_s;

    logic [CW+1:0]   dig_off_s;
    logic [4:0]      dsum_s;
    logic [4:0]      dsum_adj_s;
    logic            dcarry_s;
    logic [3:0]      ddig_s;
    logic [W-1:0]    acc_nxt_s;
    logic            c_nxt_s;

    logic            sub_s;
    logic            cin_s;
    logic [W-1:0]    b_eff_s;
    logic [W:0]      sum_w_s;
    logic [8:0]      sum_b_s;
    logic [W-1:0]    arith_res_s;
    logic            arith_c_s;
    logic            arith_v_s;
    logic [W-1:0]    logic_full_s;
    logic [W-1:0]    logic_res_s;
    logic [W-1:0]    out_res_s;
    logic [W-1:0]    flag_res_s;
    logic            c_f_s;
    logic            v_f_s;
    logic            n_f_s;
    logic            z_f_s;
    logic            upd_c_s;
    logic            upd_v_s;
    logic            pass_s;
    logic [15:0]     psw_upd_s;
    logic [15:0]     psw_fin_s;

    assign in_ready = (state_r == IDLE) && !rst;

    // Shift count clamp and EXEC cycle count for the bundle on the input
    always_comb begin
        n_in_s = op2[CW-1:0];
        if (instr[0] && (n_in_s > MAX_SH_B)) begin
            n_clamp_s = MAX_SH_B;
        end else if (!instr[0] && (n_in_s > MAX_SH_W)) begin
            n_clamp_s = MAX_SH_W;
        end else begin
            n_clamp_s = n_in_s;
        end
        case (instr[4:1])
            OP_DADD:        cnt_load_s = instr[0] ? CNT_TWO : DIGITS_W;
            OP_SRA, OP_RRC: cnt_load_s = (n_clamp_s == CNT_ZERO) ? CNT_ONE : n_clamp_s;
            default:        cnt_load_s = CNT_ONE;
        endcase
    end

    // One iterative step: a BCD digit for DADD, a single bit for SRA/RRC
    always_comb begin
        acc_nxt_s  = acc_r;
        c_nxt_s    = c_r;
        dig_off_s  = {dig_r, 2'b00};
        dsum_s     = {1'b0, acc_r[dig_off_s +: 4]} + {1'b0, op2_r[dig_off_s +: 4]} + {4'd0, c_r};
        dsum_adj_s = dsum_s - 5'd10;
        dcarry_s   = (dsum_s > 5'd9);
        ddig_s     = dcarry_s ? dsum_adj_s[3:0] : dsum_s[3:0];
        case (op_r)
            OP_DADD: begin
                acc_nxt_s[dig_off_s +: 4] = ddig_s;
                c_nxt_s = dcarry_s;
            end
            OP_SRA: begin
                if (!shen_r) begin
                    c_nxt_s = c_r;
                end else if (byte_r) begin
                    acc_nxt_s[7:0] = {acc_r[7], acc_r[7:1]};
                    c_nxt_s = acc_r[0];
                end else begin
                    acc_nxt_s = {acc_r[W-1], acc_r[W-1:1]};
                    c_nxt_s = acc_r[0];
                end
            end
            OP_RRC: begin
                if (!shen_r) begin
                    c_nxt_s = c_r;
                end else if (byte_r) begin
                    acc_nxt_s[7:0] = {c_r, acc_r[7:1]};
                    c_nxt_s = acc_r[0];
                end else begin
                    acc_nxt_s = {c_r, acc_r[W-1:1]};
                    c_nxt_s = acc_r[0];
                end
            end
            default: begin
                c_nxt_s = c_r;
            end
        endcase
    end

    // Single-cycle arithmetic/logic results and the final flag merge
    always_comb begin
        sub_s   = (op_r == OP_SUB) || (op_r == OP_SUBC) || (op_r == OP_CMP);
        b_eff_s = sub_s ? ~op2_r : op2_r;
        case (op_r)
            OP_ADD:          cin_s = 1'b0;
            OP_SUB, OP_CMP:  cin_s = 1'b1;
            default:         cin_s = psw_r[0];
        endcase
        sum_w_s = {1'b0, op1_r} + {1'b0, b_eff_s} + {{W{1'b0}}, cin_s};
        sum_b_s = {1'b0, op1_r[7:0]} + {1'b0, b_eff_s[7:0]} + {8'd0, cin_s};
        if (byte_r) begin
            arith_res_s = {op1_r[W-1:8], sum_b_s[7:0]};
            arith_c_s   = sum_b_s[8];
            arith_v_s   = (op1_r[7] == b_eff_s[7]) && (sum_b_s[7] != op1_r[7]);
        end else begin
            arith_res_s = sum_w_s[W-1:0];
            arith_c_s   = sum_w_s[W];
            arith_v_s   = (op1_r[W-1] == b_eff_s[W-1]) && (sum_w_s[W-1] != op1_r[W-1]);
        end
        case (op_r)
            OP_XOR:  logic_full_s = op1_r ^ op2_r;
            OP_AND:  logic_full_s = op1_r & op2_r;
            default: logic_full_s = op1_r | op2_r;
        endcase
        logic_res_s = byte_r ? {op1_r[W-1:8], logic_full_s[7:0]} : logic_full_s;

        out_res_s  = op1_r;
        flag_res_s = op1_r;
        c_f_s      = psw_r[0];
        v_f_s      = psw_r[4];
        upd_c_s    = 1'b0;
        upd_v_s    = 1'b0;
        pass_s     = 1'b0;
        case (op_r)
            OP_ADD, OP_ADDC, OP_SUB, OP_SUBC: begin
                out_res_s  = arith_res_s;
                flag_res_s = arith_res_s;
                c_f_s      = arith_c_s;
                v_f_s      = arith_v_s;
                upd_c_s    = 1'b1;
                upd_v_s    = 1'b1;
            end
            OP_CMP: begin
                flag_res_s = arith_res_s;
                c_f_s      = arith_c_s;
                v_f_s      = arith_v_s;
                upd_c_s    = 1'b1;
                upd_v_s    = 1'b1;
            end
            OP_XOR, OP_AND, OP_OR: begin
                out_res_s  = logic_res_s;
                flag_res_s = logic_res_s;
            end
            OP_DADD, OP_SRA, OP_RRC: begin
                out_res_s  = acc_nxt_s;
                flag_res_s = acc_nxt_s;
                c_f_s      = c_nxt_s;
                upd_c_s    = 1'b1;
            end
            default: begin
                pass_s = 1'b1;
            end
        endcase

        n_f_s = byte_r ? flag_res_s[7] : flag_res_s[W-1];
        z_f_s = byte_r ? (flag_res_s[7:0] == 8'd0) : (flag_res_s == {W{1'b0}});
        psw_upd_s    = psw_r;
        psw_upd_s[0] = upd_c_s ? c_f_s : psw_r[0];
        psw_upd_s[4] = upd_v_s ? v_f_s : psw_r[4];
        psw_upd_s[2] = n_f_s;
        psw_upd_s[1] = z_f_s;
        psw_fin_s    = (upd_r && !pass_s) ? psw_upd_s : psw_r;
    end

    // Control FSM with operand capture, iteration and held output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            op_r      <= 4'h0;
            byte_r    <= 1'b0;
            upd_r     <= 1'b0;
            op1_r     <= {W{1'b0}};
            op2_r     <= {W{1'b0}};
            psw_r     <= 16'h0000;
            acc_r     <= {W{1'b0}};
            c_r       <= 1'b0;
            cnt_r     <= CNT_ZERO;
            dig_r     <= CNT_ZERO;
            shen_r    <= 1'b0;
            out_valid <= 1'b0;
            result    <= {W{1'b0}};
            psw_o     <= 16'h0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        op_r    <= instr[4:1];
                        byte_r  <= instr[0];
                        upd_r   <= upd_psw;
                        op1_r   <= op1;
                        op2_r   <= op2;
                        psw_r   <= psw_i;
                        acc_r   <= op1;
                        c_r     <= psw_i[0];
                        cnt_r   <= cnt_load_s;
                        dig_r   <= CNT_ZERO;
                        shen_r  <= (n_clamp_s != CNT_ZERO);
                        state_r <= EXEC;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EXEC: begin
                    acc_r <= acc_nxt_s;
                    c_r   <= c_nxt_s;
                    dig_r <= dig_r + CNT_ONE;
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        result    <= out_res_s;
                        psw_o     <= psw_fin_s;
                        out_valid <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        state_r <= EXEC;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_r   <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vectors, randomized ops against an
// arithmetic reference model, backpressure and mid-operation reset.
module tb_alu_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  instr;
    logic        upd_psw;
    logic [15:0] op1;
    logic [15:0] op2;
    logic [15:0] psw_i;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [15:0] psw_o;

    int n_cmp;
    int n_bad;

    alu_seq #(.W(16), .CW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .upd_psw   (upd_psw),
        .op1       (op1),
        .op2       (op2),
        .psw_i     (psw_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .psw_o     (psw_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint sx(input longint v, input int bits);
        longint half;
        half = longint'(1) << (bits - 1);
        return (v >= half) ? v - (longint'(1) << bits) : v;
    endfunction

    // Reference model from the opcode rules using plain integer arithmetic
    function automatic void model(input logic [4:0] ins, input logic u,
                                  input logic [15:0] a_in, input logic [15:0] b_in,
                                  input logic [15:0] p_in,
                                  output logic [15:0] r_out, output logic [15:0] p_out,
                                  output int lat);
        int bits, op, n, cf, vf;
        longint mask, a, b, c, r, s, beff, cin, sv, hi, v, vm, sa, ds, carry;
        bit arith, setc, other, cmp;
        bits = ins[0] ? 8 : 16;
        op   = int'(ins[4:1]);
        mask = (longint'(1) << bits) - 1;
        a = longint'(a_in) & mask;
        b = longint'(b_in) & mask;
        c = longint'(p_in[0]);
        hi = longint'(a_in) & ~mask & 64'hFFFF;
        r = 0; cf = 0; vf = 0; lat = 1;
        arith = 0; setc = 0; other = 0; cmp = 0;
        case (op)
            0, 1, 2, 3, 5: begin
                beff = (op == 2 || op == 3 || op == 5) ? (~b & mask) : b;
                cin  = (op == 0) ? 0 : ((op == 2 || op == 5) ? 1 : c);
                s  = a + beff + cin;
                r  = s & mask;
                cf = int'((s >> bits) & 1);
                sv = sx(a, bits) + sx(beff, bits) + cin;
                vf = (sv > ((longint'(1) << (bits - 1)) - 1) || sv < -(longint'(1) << (bits - 1))) ? 1 : 0;
                arith = 1; setc = 1; cmp = (op == 5);
            end
            6: r = a ^ b;
            7: r = a & b;
            8: r = a | b;
            4: begin
                carry = c;
                for (int d = 0; d < bits / 4; d++) begin
                    ds = ((a >> (4 * d)) & 15) + ((b >> (4 * d)) & 15) + carry;
                    if (ds > 9) begin ds = ds - 10; carry = 1; end
                    else carry = 0;
                    r = r | ((ds & 15) << (4 * d));
                end
                cf = int'(carry); setc = 1; lat = bits / 4;
            end
            12, 13: begin
                n = int'(b_in & 16'h000F);
                if (n > bits - 1) n = bits - 1;
                if (op == 12) begin
                    sa = sx(a, bits);
                    r  = (sa >>> n) & mask;
                    cf = (n > 0) ? int'((sa >>> (n - 1)) & 1) : int'(c);
                end else begin
                    vm = (longint'(1) << (bits + 1)) - 1;
                    v  = (c << bits) | a;
                    v  = ((v >> n) | (v << (bits + 1 - n))) & vm;
                    r  = v & mask;
                    cf = int'((v >> bits) & 1);
                end
                setc = 1; lat = (n > 0) ? n : 1;
            end
            default: other = 1;
        endcase
        if (other) begin
            r_out = a_in; p_out = p_in;
        end else begin
            r_out = cmp ? a_in : 16'(hi | r);
            p_out = p_in;
            if (u) begin
                p_out[2] = ((r >> (bits - 1)) & 1) != 0;
                p_out[1] = (r == 0);
                if (setc)  p_out[0] = (cf != 0);
                if (arith) p_out[4] = (vf != 0);
            end
        end
    endfunction

    // Drives one bundle, waits for the result and completes the output handshake
    task automatic do_op(input logic [4:0] i_ins, input logic i_upd,
                         input logic [15:0] i_a, input logic [15:0] i_b, input logic [15:0] i_p,
                         output logic [15:0] o_r, output logic [15:0] o_p,
                         output int o_lat, output bit o_to);
        int w;
        o_to = 1; o_lat = 0; o_r = 16'h0000; o_p = 16'h0000;
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 50) begin @(negedge clk); w++; end
        instr = i_ins; upd_psw = i_upd; op1 = i_a; op2 = i_b; psw_i = i_p;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            if (out_valid) begin o_lat = cyc; o_to = 0; break; end
        end
        o_r = result; o_p = psw_o;
        if (!o_to) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        instr = 5'd0; upd_psw = 1'b0; op1 = 16'h0; op2 = 16'h0; psw_i = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (result !== 16'h0000) begin n_bad++; $display("FAIL reset_result got=%h exp=0000", result); end
        n_cmp++; if (psw_o !== 16'h0000) begin n_bad++; $display("FAIL reset_psw got=%h exp=0000", psw_o); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        @(negedge clk); rst = 1'b0; #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_directed();
        logic [4:0]  t_ins [7] = '{5'b00000, 5'b00101, 5'b01000, 5'b01000, 5'b11000, 5'b11000, 5'b10001};
        logic [15:0] t_a   [7] = '{16'h7FFF, 16'h1205, 16'h0999, 16'h9999, 16'h8004, 16'h8004, 16'hAB0F};
        logic [15:0] t_b   [7] = '{16'h0001, 16'h0006, 16'h0001, 16'h0001, 16'h0003, 16'h0000, 16'h00F0};
        logic [15:0] t_p   [7] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0008};
        logic [15:0] e_r   [7] = '{16'h8000, 16'h12FF, 16'h1000, 16'h0000, 16'hF000, 16'h8004, 16'hABFF};
        logic [15:0] e_p   [7] = '{16'h0014, 16'h0004, 16'h0000, 16'h0003, 16'h0005, 16'h0005, 16'h000C};
        int          e_l   [7] = '{1, 1, 4, 4, 3, 1, 1};
        logic [15:0] r, p;
        int lat;
        bit to;
        for (int k = 0; k < 7; k++) begin
            do_op(t_ins[k], 1'b1, t_a[k], t_b[k], t_p[k], r, p, lat, to);
            n_cmp++; if (to) begin n_bad++; $display("FAIL dir%0d_timeout got=no_out_valid exp=out_valid", k); end
            n_cmp++; if (r !== e_r[k]) begin n_bad++; $display("FAIL dir%0d_result got=%h exp=%h", k, r, e_r[k]); end
            n_cmp++; if (p !== e_p[k]) begin n_bad++; $display("FAIL dir%0d_psw got=%h exp=%h", k, p, e_p[k]); end
            n_cmp++; if (lat !== e_l[k]) begin n_bad++; $display("FAIL dir%0d_latency got=%0d exp=%0d", k, lat, e_l[k]); end
        end
    endtask

    task automatic test_random();
        logic [4:0]  ins;
        logic        u;
        logic [15:0] a, b, p, r, pr, er, ep;
        int lat, el;
        bit to;
        for (int k = 0; k < 120; k++) begin
            ins = 5'($urandom_range(0, 31));
            u   = 1'($urandom_range(0, 1));
            a   = 16'($urandom);
            b   = 16'($urandom);
            p   = 16'($urandom);
            if (ins[4:1] == 4'h4) begin
                for (int d = 0; d < 4; d++) begin
                    a[4*d +: 4] = 4'($urandom_range(0, 9));
                    b[4*d +: 4] = 4'($urandom_range(0, 9));
                end
            end
            model(ins, u, a, b, p, er, ep, el);
            do_op(ins, u, a, b, p, r, pr, lat, to);
            n_cmp++;
            if (to || r !== er || pr !== ep || lat !== el) begin
                n_bad++;
                $display("FAIL rand%0d ins=%b upd=%b a=%h b=%h psw=%h got r=%h p=%h lat=%0d to=%0d exp r=%h p=%h lat=%0d",
                         k, ins, u, a, b, p, r, pr, lat, to, er, ep, el);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit seen;
        int w;
        out_ready = 1'b0;
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 50) begin @(negedge clk); w++; end
        instr = 5'b00000; upd_psw = 1'b1; op1 = 16'h1234; op2 = 16'h1111; psw_i = 16'h0000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = 0;
        for (int cyc = 0; cyc < 20 && !seen; cyc++) begin @(posedge clk); #1; seen = out_valid; end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL bp_first_valid got=0 exp=1"); end
        instr = 5'b00100; op1 = 16'h0050; op2 = 16'h0020; psw_i = 16'h0000;
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (result !== 16'h2345 || psw_o !== 16'h0000 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold%0d got r=%h p=%h ov=%b ir=%b exp r=2345 p=0000 ov=1 ir=0",
                         cyc, result, psw_o, out_valid, in_ready);
            end
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++; $display("FAIL bp_release got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_second_accept got ir=%b exp=0", in_ready); end
        seen = 0;
        for (int cyc = 0; cyc < 20 && !seen; cyc++) begin @(posedge clk); #1; seen = out_valid; end
        n_cmp++; if (!seen || result !== 16'h0030 || psw_o !== 16'h0001) begin
            n_bad++; $display("FAIL bp_second_result got v=%0d r=%h p=%h exp v=1 r=0030 p=0001", seen, result, psw_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        bit stale;
        int w;
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 50) begin @(negedge clk); w++; end
        instr = 5'b01000; upd_psw = 1'b1; op1 = 16'h1234; op2 = 16'h4321; psw_i = 16'h0000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; #1;
        n_cmp++; if (out_valid !== 1'b0 || result !== 16'h0000 || psw_o !== 16'h0000 || in_ready !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_clear got ov=%b r=%h p=%h ir=%b exp ov=0 r=0000 p=0000 ir=0",
                              out_valid, result, psw_o, in_ready);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0; #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
        stale = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin @(posedge clk); #1; if (out_valid) stale = 1; end
        n_cmp++; if (stale) begin n_bad++; $display("FAIL rstmid_stale got out_valid=1 exp=0"); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
